// File: rtl/multiport_regfile.sv
// multiport_regfile
//   Register file with NREAD combinational read ports and one byte-masked
//   write port. Register 0 is hard-wired to zero. Writes bypass to any read
//   port addressing the written register in the same cycle. A Clear request
//   (or reset) zeroes every register sequentially, one per cycle, while Busy
//   is high.
//
// Ports
//   clk          clock, all state updates on the rising edge
//   rst          synchronous active-high reset (starts a full clear)
//   Read         NREAD read addresses, port k at [k*AW +: AW]
//   Data         NREAD read data words, port k at [k*WIDTH +: WIDTH]
//   WriteReg     write address
//   RegWrite     write enable
//   WriteByteEn  per-byte write mask
//   WriteData    write data
//   Clear        request a full sequential clear
//   Busy         high while a clear sequence is running
//   WriteDropped one-cycle pulse after a discarded write request
module multiport_regfile #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32,
    parameter int AW    = 5,
    parameter int NREAD = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREAD*AW-1:0]    Read,
    output logic [NREAD*WIDTH-1:0] Data,
    input  logic [AW-1:0]          WriteReg,
    input  logic                   RegWrite,
    input  logic [WIDTH/8-1:0]     WriteByteEn,
    input  logic [WIDTH-1:0]       WriteData,
    input  logic                   Clear,
    output logic                   Busy,
    output logic                   WriteDropped
);

    localparam int NBYTE = WIDTH / 8;

    localparam logic [0:0] READY = 1'b0;
    localparam logic [0:0] CLEAR = 1'b1;

    logic [0:0]       state;
    logic [AW-1:0]    cnt;
    logic [WIDTH-1:0] mem [DEPTH];

    logic             wr_ok;
    logic             clr_last;
    logic [WIDTH-1:0] wr_merged;
    logic [AW-1:0]    ra;

    assign Busy     = (state == CLEAR);
    assign wr_ok    = RegWrite && !Busy && (WriteReg != '0);
    assign clr_last = (cnt == AW'(DEPTH - 1));

    // Value the write target will hold after the edge: enabled bytes from
    // WriteData, the rest from storage. Shared by the write path and bypass.
    always_comb begin
        // NOTE: every always_comb output gets a full default first so no
        // path through the block leaves it unassigned (which would infer a latch).
        wr_merged = mem[WriteReg];
        for (int b = 0; b < NBYTE; b++) begin
            if (WriteByteEn[b]) begin
                wr_merged[8*b +: 8] = WriteData[8*b +: 8];
            end
        end
    end

    // Control state: clear sequencer and drop flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= CLEAR;
            cnt          <= '0;
            WriteDropped <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every
            // register here samples pre-edge values regardless of statement order.
            WriteDropped <= RegWrite && (Busy || (WriteReg == '0));
            case (state)
                CLEAR: begin
                    // Clear requests here are ignored; the counter runs on.
                    if (clr_last) begin
                        state <= READY;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + AW'(1);
                    end
                end
                default: begin
                    if (Clear) begin
                        state <= CLEAR;
                        cnt   <= '0;
                    end
                end
            endcase
        end
    end

    // Storage. A write accepted in the same cycle as Clear still lands,
    // since Busy only rises after that edge.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset branch; it is zeroed by the sequential
        // clear instead, which keeps it mappable to plain RAM/flop arrays.
        if (!rst) begin
            if (Busy) begin
                mem[cnt] <= '0;
            end else if (wr_ok) begin
                mem[WriteReg] <= wr_merged;
            end
        end
    end

    // Read ports: zero while clearing, zero for register 0, bypass on a
    // same-cycle write to the addressed register.
    always_comb begin
        Data = '0;
        ra   = '0;
        for (int k = 0; k < NREAD; k++) begin
            ra = Read[k*AW +: AW];
            if (!Busy && (ra != '0)) begin
                Data[k*WIDTH +: WIDTH] = (wr_ok && (ra == WriteReg)) ? wr_merged : mem[ra];
            end
        end
    end

endmodule

// File: tb/tb_multiport_regfile.sv
// tb_multiport_regfile
//   Directed bench for multiport_regfile with default parameters: a table of
//   single-cycle read/write vectors plus hand-written clear and reset
//   sequences. Inputs change on the falling edge; Data is checked before the
//   rising edge and registered outputs just after it.
module tb_multiport_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  Read;
    logic [63:0] Data;
    logic [4:0]  WriteReg;
    logic        RegWrite;
    logic [3:0]  WriteByteEn;
    logic [31:0] WriteData;
    logic        Clear;
    logic        Busy;
    logic        WriteDropped;

    multiport_regfile dut (
        .clk          (clk),
        .rst          (rst),
        .Read         (Read),
        .Data         (Data),
        .WriteReg     (WriteReg),
        .RegWrite     (RegWrite),
        .WriteByteEn  (WriteByteEn),
        .WriteData    (WriteData),
        .Clear        (Clear),
        .Busy         (Busy),
        .WriteDropped (WriteDropped)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] exp0;
        logic [31:0] exp1;
        logic        exp_drop;
    } vec_t;

    vec_t vecs [12];
    int   n_vec  = 0;
    int   n_miss = 0;
    int   cycles;
    int   prev_wr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        RegWrite    = 1'b0;
        WriteReg    = '0;
        WriteByteEn = '0;
        WriteData   = '0;
        Clear       = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 5'd5,  4'hF, 32'h5555_5555, 5'd5,  5'd5,  32'h5555_5555, 32'h5555_5555, 1'b0};
        vecs[1]  = '{1'b1, 5'd10, 4'hF, 32'hAAAA_AAAA, 5'd10, 5'd5,  32'hAAAA_AAAA, 32'h5555_5555, 1'b0};
        vecs[2]  = '{1'b0, 5'd0,  4'h0, 32'h0,         5'd10, 5'd5,  32'hAAAA_AAAA, 32'h5555_5555, 1'b0};
        vecs[3]  = '{1'b1, 5'd5,  4'h5, 32'h1234_5678, 5'd5,  5'd5,  32'h5534_5578, 32'h5534_5578, 1'b0};
        vecs[4]  = '{1'b0, 5'd0,  4'h0, 32'h0,         5'd5,  5'd5,  32'h5534_5578, 32'h5534_5578, 1'b0};
        vecs[5]  = '{1'b1, 5'd0,  4'hF, 32'hFFFF_FFFF, 5'd0,  5'd0,  32'h0,         32'h0,         1'b1};
        vecs[6]  = '{1'b0, 5'd0,  4'h0, 32'h0,         5'd0,  5'd5,  32'h0,         32'h5534_5578, 1'b0};
        vecs[7]  = '{1'b1, 5'd10, 4'h0, 32'h1111_1111, 5'd10, 5'd10, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 1'b0};
        vecs[8]  = '{1'b0, 5'd0,  4'h0, 32'h0,         5'd10, 5'd3,  32'hAAAA_AAAA, 32'h0,         1'b0};
        vecs[9]  = '{1'b1, 5'd3,  4'hC, 32'hDEAD_BEEF, 5'd3,  5'd10, 32'hDEAD_0000, 32'hAAAA_AAAA, 1'b0};
        vecs[10] = '{1'b1, 5'd31, 4'hF, 32'hCAFE_F00D, 5'd30, 5'd31, 32'h0,         32'hCAFE_F00D, 1'b0};
        vecs[11] = '{1'b0, 5'd0,  4'h0, 32'h0,         5'd31, 5'd3,  32'hCAFE_F00D, 32'hDEAD_0000, 1'b0};

        // Reset and the initial clear.
        idle();
        rst  = 1'b1;
        Read = {5'd31, 5'd7};
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("reset_busy", 64'(Busy), 64'd1);
        check("reset_drop", 64'(WriteDropped), 64'd0);
        check("reset_data", Data, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        cycles = 0;
        while (Busy && cycles < 100) begin
            @(posedge clk); #1;
            cycles++;
        end
        check("init_clear_edges", 64'(cycles), 64'd32);
        @(negedge clk);
        Read = {5'd31, 5'd0};
        #1;
        check("init_data_zero", Data, 64'd0);

        // Table-driven read/write vectors.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            RegWrite    = vecs[i].we;
            WriteReg    = vecs[i].wa;
            WriteByteEn = vecs[i].be;
            WriteData   = vecs[i].wd;
            Read        = {vecs[i].ra1, vecs[i].ra0};
            #1;
            check($sformatf("vec%0d_data0", i), 64'(Data[31:0]),  64'(vecs[i].exp0));
            check($sformatf("vec%0d_data1", i), 64'(Data[63:32]), 64'(vecs[i].exp1));
            @(posedge clk); #1;
            check($sformatf("vec%0d_drop", i), 64'(WriteDropped), 64'(vecs[i].exp_drop));
        end

        // Clear with a simultaneous write, a dropped write at clear cycle 4,
        // and an ignored Clear at clear cycle 10.
        @(negedge clk);
        Clear       = 1'b1;
        RegWrite    = 1'b1;
        WriteReg    = 5'd7;
        WriteByteEn = 4'hF;
        WriteData   = 32'h0102_0304;
        @(posedge clk); #1;
        check("clear_start_busy", 64'(Busy), 64'd1);
        check("clear_start_write_kept", 64'(WriteDropped), 64'd0);
        cycles  = 1;
        prev_wr = 0;
        while (Busy && cycles < 100) begin
            @(negedge clk);
            idle();
            RegWrite    = (cycles == 4);
            WriteReg    = 5'd3;
            WriteByteEn = 4'hF;
            WriteData   = 32'hFFFF_FFFF;
            Clear       = (cycles == 10);
            Read        = {5'd5, 5'd3};
            #1;
            if (cycles == 4) check("busy_data_zero", Data, 64'd0);
            @(posedge clk); #1;
            if (cycles == 4) check("busy_write_drop", 64'(WriteDropped), 64'd1);
            if (prev_wr != 0) check("busy_drop_one_cycle", 64'(WriteDropped), 64'd0);
            prev_wr = (cycles == 4) ? 1 : 0;
            if (Busy) cycles++;
        end
        check("clear_busy_cycles", 64'(cycles), 64'd32);
        @(negedge clk);
        idle();
        Read = {5'd7, 5'd3};
        #1;
        check("after_clear_r3_r7", Data, 64'd0);

        // Reset in the middle of a clear restarts the sequence.
        @(negedge clk);
        RegWrite    = 1'b1;
        WriteReg    = 5'd9;
        WriteByteEn = 4'hF;
        WriteData   = 32'h9999_0000;
        @(posedge clk);
        @(negedge clk);
        idle();
        Read = {5'd9, 5'd9};
        #1;
        check("r9_written", Data, {32'h9999_0000, 32'h9999_0000});
        Clear = 1'b1;
        @(posedge clk); #1;
        cycles = 1;
        @(negedge clk);
        Clear = 1'b0;
        while (cycles < 20) begin
            @(posedge clk); #1;
            cycles++;
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_reset_busy", 64'(Busy), 64'd1);
        check("mid_reset_data", Data, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        cycles = 0;
        while (Busy && cycles < 100) begin
            @(posedge clk); #1;
            cycles++;
        end
        check("mid_reset_clear_edges", 64'(cycles), 64'd32);
        for (int a = 0; a < 32; a += 2) begin
            @(negedge clk);
            Read = {5'(a + 1), 5'(a)};
            #1;
            check($sformatf("final_zero_r%0d", a), Data, 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/multiport_regfile.md
MULTIPORT_REGFILE -- requirements
Module: multiport_regfile

Interface
- REQ-001: Parameter WIDTH, default 32, data word width in bits; SHALL be a multiple of 8.
- REQ-002: Parameter DEPTH, default 32, number of registers; SHALL be a power of two, at least 2.
- REQ-003: Parameter AW, default 5, register address width; SHALL equal log2(DEPTH).
- REQ-004: Parameter NREAD, default 2, number of independent read ports; SHALL be at least 1.
- REQ-005: clk  in  1  single clock; all state SHALL update on the rising edge.
- REQ-006: rst  in  1  reset; synchronous, active-high.
- REQ-007: Read  in  NREAD*AW  read addresses, port k at bits [k*AW +: AW].
- REQ-008: Data  out  NREAD*WIDTH  read data, port k at bits [k*WIDTH +: WIDTH].
- REQ-009: WriteReg  in  AW  write address.
- REQ-010: RegWrite  in  1  write enable.
- REQ-011: WriteByteEn  in  WIDTH/8  per-byte write mask; bit b covers data bits [8b+7:8b].
- REQ-012: WriteData  in  WIDTH  write data.
- REQ-013: Clear  in  1  request a full sequential clear of all registers.
- REQ-014: Busy  out  1  high while a clear sequence is in progress.
- REQ-015: WriteDropped  out  1  registered one-cycle pulse when a requested write is discarded.

Function
- REQ-016: Storage SHALL be DEPTH registers of WIDTH bits; register 0 SHALL always read as zero, and writes to it SHALL be discarded.
- REQ-017: Write: on the rising edge with RegWrite=1, Busy=0 and WriteReg!=0, each byte b with WriteByteEn[b]=1 SHALL take WriteData byte b; masked bytes SHALL hold their value.
- REQ-018: Read ports SHALL be combinational; Data port k SHALL reflect the register addressed by Read port k in the same cycle.
- REQ-019: Bypass: when Busy=0, RegWrite=1, WriteReg!=0 and Read port k equals WriteReg, Data port k SHALL return the value the register will hold after the edge (enabled bytes from WriteData, other bytes from the stored value).
- REQ-020: All read ports SHALL be independent; any number of them may address the same register, including WriteReg, in the same cycle.
- REQ-021: The state machine SHALL have two states: CLEAR and READY.
- REQ-022: In CLEAR, each rising edge SHALL zero the register at the clear counter and increment the counter; when the counter reaches DEPTH-1, the next state SHALL be READY and the counter SHALL return to 0.
- REQ-023: A full clear SHALL take exactly DEPTH cycles; Busy SHALL be 1 exactly while in CLEAR.
- REQ-024: In READY, Clear=1 SHALL move to CLEAR with the counter at 0 on the next edge; a write presented in that same cycle SHALL still be performed.
- REQ-025: Clear=1 while already in CLEAR SHALL be ignored, and SHALL NOT restart the counter.
- REQ-026: While Busy=1, every Data port SHALL read 0.
- REQ-027: WriteDropped SHALL be 1 in the cycle after any edge where RegWrite=1 and either Busy=1 or WriteReg=0; otherwise it SHALL be 0.
- REQ-028: A write with RegWrite=1 and WriteByteEn all zero SHALL leave storage unchanged and SHALL NOT assert WriteDropped.

Reset
- REQ-029: rst=1 at an edge SHALL set the state to CLEAR, the counter to 0 and WriteDropped to 0; Busy SHALL read 1 and all Data ports SHALL read 0 from that edge onward.
- REQ-030: After rst is released, Busy SHALL fall exactly DEPTH edges later, with every register reading 0 at that point.
- REQ-031: rst asserted in the middle of a clear SHALL restart the counter at 0; rst SHALL take priority over Clear and over writes.

Verification
- REQ-032: Release rst, count edges until Busy=0 -> exactly 32 with defaults; Read={5'd0,5'd31} -> Data all zero.
- REQ-033: Write 0x55555555 to r5 with byte enable 4'hF, then write 0xAAAAAAAA to r10; read r5 and r10 on ports 1 and 0 -> 0x55555555 and 0xAAAAAAAA, WriteDropped=0.
- REQ-034: With r5=0x55555555, write 0x12345678 to r5 with byte enable 4'b0101 while both ports read r5 -> same-cycle Data 0x55345578 on both ports, and the stored value afterwards is 0x55345578.
- REQ-035: Write 0xFFFFFFFF to r0 -> r0 reads 0 and WriteDropped pulses for one cycle.
- REQ-036: Pulse Clear, attempt a write to r3 at cycle 4 of the clear -> write discarded, WriteDropped pulses, Busy=1 for 32 cycles, then r3=0.
- REQ-037: Assert rst at clear cycle 20 for one cycle -> Busy stays 1 for 32 further cycles, then all registers read 0.
